// File: rtl/peri_arb_pkg.sv
// Shared types and constants for the peripheral-bus arbiter.
// The forced-completion data word is used only when PERI_ARB_TIMEOUT_EN is defined.
package peri_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  localparam logic [31:0] PERI_TIMEOUT_RDATA = 32'hDEAD_BEEF;
  localparam int unsigned PERI_TO_CNT_W      = 16;
  localparam int unsigned PERI_ID_W_MIN      = 1;

  // Owner-id width for a given PE count; never narrower than one bit.
  function automatic int unsigned peri_id_w(input int unsigned num_pe);
    return (num_pe > 2) ? $clog2(num_pe) : PERI_ID_W_MIN;
  endfunction

endpackage

// File: rtl/peri_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr,
// wrapping from NUM_PE-1 back to 0.
module peri_rr_pick
  import peri_arb_pkg::*;
#(
  parameter int unsigned NUM_PE = 3,
  parameter int unsigned ID_W   = peri_id_w(NUM_PE)
) (
  input  logic [NUM_PE-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  output logic              valid,
  output logic [ID_W-1:0]   idx
);

  int unsigned     cand;
  logic [ID_W-1:0] cand_id;

  always_comb begin
    valid   = 1'b0;
    idx     = '0;
    cand    = 0;
    cand_id = '0;
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      cand    = (32'(ptr) + i) % NUM_PE;
      cand_id = ID_W'(cand);
      if (!valid && req[cand_id]) begin
        valid = 1'b1;
        idx   = cand_id;
      end
    end
  end

endmodule

// File: rtl/peri_arbiter.sv
// Round-robin arbiter sharing one peripheral bus among NUM_PE requesters.
// Define PERI_ARB_TIMEOUT_EN to force completion after TIMEOUT_CYC WAIT cycles.
module peri_arbiter
  import peri_arb_pkg::*;
#(
  parameter int unsigned NUM_PE      = 3,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_PE-1:0]              i_pe_rden,
  input  logic [NUM_PE-1:0]              i_pe_wren,
  input  logic [NUM_PE*32-1:0]           i_pe_addr,
  input  logic [NUM_PE*32-1:0]           i_pe_wdata,
  input  logic [NUM_PE*4-1:0]            i_pe_wstrb,
  output logic [NUM_PE-1:0]              o_pe_gnt,
  output logic [NUM_PE-1:0]              o_pe_ready,
  output logic [31:0]                    o_pe_rdata,
  output logic                           o_peri_rden,
  output logic                           o_peri_wren,
  output logic [31:0]                    o_peri_addr,
  output logic [31:0]                    o_peri_wdata,
  output logic [3:0]                     o_peri_wstrb,
  output logic [peri_id_w(NUM_PE)-1:0]   o_peri_pe_id,
  input  logic [31:0]                    i_peri_rdata,
  input  logic                           i_peri_ready,
  output logic                           o_timeout
);

  localparam int unsigned     ID_W    = peri_id_w(NUM_PE);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_PE - 1);

  typedef logic [PERI_TO_CNT_W-1:0] to_cnt_t;

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_valid;
  logic [NUM_PE-1:0] pend;
  logic              load;
  logic              done;
  logic              to_hit;

  logic [NUM_PE-1:0] gnt_d, ready_d;
  logic              rden_d, wren_d, to_d;
  logic [31:0]       rdata_d;

  assign pend = i_pe_rden | i_pe_wren;

  peri_rr_pick #(
    .NUM_PE (NUM_PE),
    .ID_W   (ID_W)
  ) u_pick (
    .req   (pend),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign load = (state_q == IDLE) && pick_valid;
  assign done = ((state_q == ISSUE) && i_peri_ready) ||
                ((state_q == WAIT)  && (i_peri_ready || to_hit));

`ifdef PERI_ARB_TIMEOUT_EN
  to_cnt_t to_cnt_q;

  // Cleared while issuing so it reads zero on the first WAIT cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      to_cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      to_cnt_q <= '0;
    end else if ((state_q == WAIT) && !done) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign to_hit = (state_q == WAIT) && (to_cnt_q == to_cnt_t'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^to_cnt_t'(TIMEOUT_CYC);
  assign to_hit             = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_valid) state_d = ISSUE;
      ISSUE:   state_d = i_peri_ready ? IDLE : WAIT;
      WAIT:    if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; a ready wins over a same-cycle timeout.
  always_comb begin
    gnt_d   = '0;
    ready_d = '0;
    rden_d  = 1'b0;
    wren_d  = 1'b0;
    to_d    = 1'b0;
    rdata_d = '0;
    if (load) begin
      gnt_d[pick_idx] = 1'b1;
      wren_d          = i_pe_wren[pick_idx];
      rden_d          = !i_pe_wren[pick_idx];
    end
    if (done) begin
      ready_d[o_peri_pe_id] = 1'b1;
      if (i_peri_ready) begin
        rdata_d = i_peri_rdata;
      end else begin
        rdata_d = PERI_TIMEOUT_RDATA;
        to_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else if (load) begin
      ptr_q <= (pick_idx == LAST_ID) ? '0 : pick_idx + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_pe_gnt     <= '0;
      o_pe_ready   <= '0;
      o_pe_rdata   <= '0;
      o_peri_rden  <= 1'b0;
      o_peri_wren  <= 1'b0;
      o_peri_addr  <= '0;
      o_peri_wdata <= '0;
      o_peri_wstrb <= '0;
      o_peri_pe_id <= '0;
      o_timeout    <= 1'b0;
    end else begin
      o_pe_gnt    <= gnt_d;
      o_pe_ready  <= ready_d;
      o_pe_rdata  <= rdata_d;
      o_peri_rden <= rden_d;
      o_peri_wren <= wren_d;
      o_timeout   <= to_d;
      if (load) begin
        o_peri_addr  <= i_pe_addr[32*pick_idx +: 32];
        o_peri_wdata <= i_pe_wdata[32*pick_idx +: 32];
        o_peri_wstrb <= i_pe_wstrb[4*pick_idx +: 4];
        o_peri_pe_id <= pick_idx;
      end
    end
  end

endmodule
